// File: rtl/conv_y_out_buffer_if.sv
// Handshake bundle between the conv core y stream, the output buffer and its consumer.
interface conv_y_out_buffer_if #(
  parameter int unsigned ACC_SIZE  = 21,
  parameter int unsigned OUT_WIDTH = 21
);
  logic                        s_valid_y;
  logic                        s_ready_y;
  logic signed [ACC_SIZE-1:0]  s_data_in_y;
  logic                        m_valid;
  logic                        m_ready;
  logic signed [OUT_WIDTH-1:0] m_data_out;
  logic                        m_last;
  logic                        sat_flag;

  modport slave (
    input  s_valid_y, s_data_in_y, m_ready,
    output s_ready_y, m_valid, m_data_out, m_last, sat_flag
  );

  modport master (
    output s_valid_y, s_data_in_y, m_ready,
    input  s_ready_y, m_valid, m_data_out, m_last, sat_flag
  );
endinterface

// File: rtl/conv_y_out_buffer.sv
// FWFT output FIFO for the conv core y stream: saturates on push and tags the
// last sample of every frame. All interface outputs come straight from flops.
module conv_y_out_buffer #(
  parameter int unsigned ACC_SIZE  = 21,
  parameter int unsigned OUT_WIDTH = 21,
  parameter int unsigned X_SIZE    = 128,
  parameter int unsigned F_SIZE    = 32,
  parameter int unsigned DEPTH     = 4
) (
  input logic                 clk,
  input logic                 reset,
  conv_y_out_buffer_if.slave  bus
);
  localparam int unsigned Y_COUNT = X_SIZE - F_SIZE + 1;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned FCNT_W  = (Y_COUNT > 1) ? $clog2(Y_COUNT) : 1;
  localparam int unsigned ENT_W   = OUT_WIDTH + 1;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FCNT_W-1:0] frame_q, frame_d;
  logic              sat_q, sat_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic [ENT_W-1:0]  head_q, head_d;

  logic                 push_c, pop_c, clamp_c, last_c;
  logic [OUT_WIDTH-1:0] sat_data_c;
  logic [ENT_W-1:0]     entry_c;

  // Clamp when the bits above the output sign bit are not a pure sign extension.
  if (OUT_WIDTH < ACC_SIZE) begin : g_sat
    localparam int unsigned HI_W = ACC_SIZE - OUT_WIDTH + 1;
    logic [HI_W-1:0] hi_c;
    assign hi_c = bus.s_data_in_y[ACC_SIZE-1:OUT_WIDTH-1];
    always_comb begin
      clamp_c    = !((&hi_c) || !(|hi_c));
      sat_data_c = bus.s_data_in_y[OUT_WIDTH-1:0];
      if (clamp_c) begin
        sat_data_c = bus.s_data_in_y[ACC_SIZE-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end else begin : g_pass
    assign clamp_c    = 1'b0;
    assign sat_data_c = bus.s_data_in_y[OUT_WIDTH-1:0];
  end

  assign push_c  = bus.s_valid_y && s_ready_q;
  assign pop_c   = m_valid_q && bus.m_ready;
  assign last_c  = (frame_q == FCNT_W'(Y_COUNT - 1));
  assign entry_c = {last_c, sat_data_c};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    frame_d  = frame_q;
    sat_d    = sat_q;
    head_d   = '0;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      frame_d  = last_c ? '0 : frame_q + FCNT_W'(1);
      sat_d    = sat_q | clamp_c;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head register: bypass the incoming entry when it lands in an empty FIFO.
    if (count_d == '0) begin
      head_d = '0;
    end else if ((count_q - CNT_W'(pop_c)) == '0) begin
      head_d = entry_c;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    s_ready_d = (count_d != CNT_W'(DEPTH));
    m_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      frame_q   <= '0;
      sat_q     <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      head_q    <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      frame_q   <= frame_d;
      sat_q     <= sat_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      head_q    <= head_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_c;
    end
  end

  assign bus.s_ready_y  = s_ready_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data_out = head_q[OUT_WIDTH-1:0];
  assign bus.m_last     = head_q[OUT_WIDTH];
  assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_conv_y_out_buffer.sv
// Scoreboard bench: a 21-bit pass-through buffer and a 16-bit saturating buffer
// receive identical stimulus; a reference model queues expectations for both.
module tb_conv_y_out_buffer;
  localparam int DEPTH   = 4;
  localparam int Y_COUNT = 97;

  typedef struct { int data; bit last; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  int   s_data = 0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mcount = 0;
  int mframe = 0;
  bit msat = 1'b0;
  int pops21 = 0;
  int lasts21 = 0;
  exp_t q21[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_y_out_buffer_if #(.ACC_SIZE(21), .OUT_WIDTH(21)) bus21 ();
  conv_y_out_buffer_if #(.ACC_SIZE(21), .OUT_WIDTH(16)) bus16 ();

  assign bus21.s_valid_y   = s_valid;
  assign bus21.s_data_in_y = 21'(s_data);
  assign bus21.m_ready     = m_ready;
  assign bus16.s_valid_y   = s_valid;
  assign bus16.s_data_in_y = 21'(s_data);
  assign bus16.m_ready     = m_ready;

  conv_y_out_buffer #(.ACC_SIZE(21), .OUT_WIDTH(21), .X_SIZE(128), .F_SIZE(32), .DEPTH(DEPTH))
    dut21 (.clk(clk), .reset(reset), .bus(bus21.slave));
  conv_y_out_buffer #(.ACC_SIZE(21), .OUT_WIDTH(16), .X_SIZE(128), .F_SIZE(32), .DEPTH(DEPTH))
    dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference model: occupancy, frame position and sticky saturation.
  always @(negedge clk) begin
    bit push, pop, last;
    if (reset) begin
      q21.delete(); q16.delete();
      mcount = 0; mframe = 0; msat = 1'b0;
    end else begin
      chk("s_ready21", int'(bus21.s_ready_y), int'(mcount != DEPTH));
      chk("s_ready16", int'(bus16.s_ready_y), int'(mcount != DEPTH));
      chk("m_valid21", int'(bus21.m_valid), int'(mcount != 0));
      chk("m_valid16", int'(bus16.m_valid), int'(mcount != 0));
      chk("sat21", int'(bus21.sat_flag), 0);
      chk("sat16", int'(bus16.sat_flag), int'(msat));
      push = s_valid && (mcount != DEPTH);
      pop  = (mcount != 0) && m_ready;
      if (push) begin
        last = (mframe == Y_COUNT - 1);
        q21.push_back('{data: s_data, last: last});
        q16.push_back('{data: sat16(s_data), last: last});
        if (sat16(s_data) != s_data) msat = 1'b1;
        mframe = last ? 0 : mframe + 1;
      end
      mcount = mcount + int'(push) - int'(pop);
    end
  end

  // Output monitors: compare every popped sample against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus21.m_valid && m_ready) begin
      if (q21.size() == 0) begin
        chk("q21_underflow", 1, 0);
      end else begin
        e = q21.pop_front();
        chk("data21", int'(bus21.m_data_out), e.data);
        chk("last21", int'(bus21.m_last), int'(e.last));
      end
      pops21++;
      if (bus21.m_last) lasts21++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus16.m_valid && m_ready) begin
      if (q16.size() == 0) begin
        chk("q16_underflow", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("data16", int'(bus16.m_data_out), e.data);
        chk("last16", int'(bus16.m_last), int'(e.last));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample is accepted.
  task automatic send(input int v);
    int n = 0;
    s_data = v;
    s_valid = 1'b1;
    @(negedge clk);
    while (!bus21.s_ready_y && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("send_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (mcount != 0 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) chk("drain_timeout", n, 0);
    idle(1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_valid21", int'(bus21.m_valid), 0);
    chk("rst_data21", int'(bus21.m_data_out), 0);
    chk("rst_last21", int'(bus21.m_last), 0);
    chk("rst_valid16", int'(bus16.m_valid), 0);
    chk("rst_data16", int'(bus16.m_data_out), 0);
    chk("rst_sat16", int'(bus16.sat_flag), 0);
  endtask

  initial begin
    int t0, p0, l0;
    bit done;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, p0, l0;
    bit done;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single sample, no stall.
    m_ready = 1'b1;
    send(1234);
    s_valid = 1'b0;
    chk("latency_valid", int'(bus21.m_valid), 1);
    chk("latency_data", int'(bus21.m_data_out), 1234);
    idle(2);

    // Backpressure: fill the FIFO, then release the consumer.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i);
    s_data = 5; s_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("full_ready", int'(bus21.s_ready_y), 0);
    m_ready = 1'b1;
    send(5);
    send(6);
    drain();

    // Continuous stream: one sample per cycle.
    t0 = cyc; p0 = pops21;
    for (int i = 0; i < 200; i++) send(i * 3 - 300);
    chk("stream_cycles", cyc - t0, 200);
    idle(2);
    chk("stream_pops", pops21 - p0, 200);

    // Saturation boundaries on the 16-bit instance.
    send(40000); send(-40000); send(32767); send(-32768); send(32768); send(-32769);
    drain();
    chk("sat_sticky", int'(bus16.sat_flag), 1);

    // Frame tagging under an irregular consumer.
    do_reset();
    l0 = lasts21; done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * Y_COUNT; i++) send(i + 7);
        done = 1'b1;
      end
      begin
        int k = 0;
        while (!done) begin
          m_ready = ((k % 3) != 0) || ((k % 7) == 0);
          k++;
          @(posedge clk); #1;
        end
      end
    join
    drain();
    chk("frame_lasts", lasts21 - l0, 2);

    // Reset mid-frame with buffered data and a saturated sample.
    m_ready = 1'b1;
    for (int i = 0; i < 47; i++) send((i == 10) ? 50000 : i);
    m_ready = 1'b0;
    for (int i = 47; i < 50; i++) send(i);
    chk("pre_rst_sat16", int'(bus16.sat_flag), 1);
    do_reset();
    l0 = lasts21;
    m_ready = 1'b1;
    for (int i = 0; i < Y_COUNT; i++) send(-i);
    drain();
    chk("post_rst_lasts", lasts21 - l0, 1);
    chk("q21_empty", q21.size(), 0);
    chk("q16_empty", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
